// File: rtl/addsub_bcd_seq_pkg.sv
// Shared types and constants for the sequential add/sub + binary-to-BCD converter.
package addsub_bcd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Smallest digit count whose decimal range covers the largest magnitude 2^(width+1)-2.
  function automatic int min_digits(input int width);
    longint max_v;
    longint pow_v;
    int     d;
    max_v = (64'sd1 <<< (width + 1)) - 64'sd2;
    pow_v = 64'sd1;
    d     = 0;
    for (int i = 0; i < 19; i++) begin
      if (pow_v <= max_v) begin
        pow_v = pow_v * 64'sd10;
        d     = d + 1;
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/addsub_bcd_seq_bcd_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module addsub_bcd_seq_bcd_add3
  import addsub_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  // Add-3 correction so that the following left shift carries correctly into the next digit
  always_comb begin
    adj = digit;
    if (digit >= ADD3_THRESH) begin
      adj = digit + 4'd3;
    end else begin
      adj = digit;
    end
  end

endmodule

// File: rtl/addsub_bcd_seq.sv
// Sequential add/sub of two unsigned operands with an iterative shift-add-3 BCD
// conversion of the result magnitude, under a start/done handshake.
module addsub_bcd_seq
  import addsub_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic                   Sel,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH:0]         resultado,
  output logic                   negative,
  output logic [4*DIGITS-1:0]    bcd
);

  localparam int RW = WIDTH + 1;
  localparam int BW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 2);

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_too_small
    $error("addsub_bcd_seq: DIGITS too small for WIDTH");
  end

  state_t            state_r, state_next_s;
  logic [WIDTH-1:0]  a_r, b_r;
  logic              sel_r;
  logic [RW-1:0]     raw_r, raw_s, mag_s, shift_r;
  logic              neg_r, neg_s;
  logic [BW-1:0]     acc_r, acc_adj_s, acc_next_s;
  logic [CW-1:0]     cnt_r;
  logic              last_s;
  logic              busy_r, done_r, negative_r;
  logic [RW-1:0]     resultado_r;
  logic [BW-1:0]     bcd_r;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    addsub_bcd_seq_bcd_add3 u_add3 (
      .digit (acc_r[g*DIGIT_W +: DIGIT_W]),
      .adj   (acc_adj_s[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign acc_next_s = {acc_adj_s[BW-2:0], shift_r[RW-1]};
  assign last_s     = (cnt_r == CW'(WIDTH));

  // Raw result and magnitude; an addition is never negative, so only a subtraction's borrow sets the sign
  always_comb begin
    raw_s = {1'b0, a_r} + {1'b0, b_r};
    if (sel_r) begin
      raw_s = {1'b0, a_r} - {1'b0, b_r};
    end else begin
      raw_s = {1'b0, a_r} + {1'b0, b_r};
    end
    neg_s = sel_r & raw_s[RW-1];
    mag_s = raw_s;
    if (neg_s) begin
      mag_s = ~raw_s + RW'(1);
    end else begin
      mag_s = raw_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_LOAD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD:    state_next_s = S_CONVERT;
      S_CONVERT: begin
        if (last_s) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_CONVERT;
        end
      end
      S_DONE:    state_next_s = S_IDLE;
      default:   state_next_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, conversion datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      sel_r       <= 1'b0;
      raw_r       <= '0;
      neg_r       <= 1'b0;
      shift_r     <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      resultado_r <= '0;
      negative_r  <= 1'b0;
      bcd_r       <= '0;
    end else begin
      busy_r <= (state_next_s != S_IDLE);
      done_r <= (state_next_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            a_r   <= A;
            b_r   <= B;
            sel_r <= Sel;
          end
        end
        S_LOAD: begin
          raw_r   <= raw_s;
          neg_r   <= neg_s;
          shift_r <= mag_s;
          acc_r   <= '0;
          cnt_r   <= '0;
        end
        S_CONVERT: begin
          acc_r   <= acc_next_s;
          shift_r <= {shift_r[RW-2:0], 1'b0};
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            resultado_r <= raw_r;
            negative_r  <= neg_r;
            bcd_r       <= acc_next_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign resultado = resultado_r;
  assign negative  = negative_r;
  assign bcd       = bcd_r;

endmodule

// File: tb/tb_addsub_bcd_seq.sv
// Directed bench for addsub_bcd_seq: WIDTH=8/DIGITS=3 instance plus a WIDTH=4/DIGITS=2 variant.
module tb_addsub_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, Sel;
  logic [7:0]  A, B;
  logic        busy, done, negative;
  logic [8:0]  resultado;
  logic [11:0] bcd;

  logic        start4, Sel4;
  logic [3:0]  A4, B4;
  logic        busy4, done4, negative4;
  logic [4:0]  resultado4;
  logic [7:0]  bcd4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addsub_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Sel(Sel),
    .busy(busy), .done(done), .resultado(resultado), .negative(negative), .bcd(bcd)
  );

  addsub_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .Sel(Sel4),
    .busy(busy4), .done(done4), .resultado(resultado4), .negative(negative4), .bcd(bcd4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation on the 8-bit instance with latency, busy length and result checks
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sel,
                        input logic [8:0] exp_res, input logic exp_neg, input logic [11:0] exp_bcd);
    int edges;
    int busy_cycles;
    @(negedge clk);
    A = a; B = b; Sel = sel; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    busy_cycles = busy ? 1 : 0;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cycles++;
    end
    check_eq("latency", edges, 11);
    check_eq("busy_cycles", busy_cycles, 11);
    check_eq("resultado", {23'd0, resultado}, {23'd0, exp_res});
    check_eq("negative", {31'd0, negative}, {31'd0, exp_neg});
    check_eq("bcd", {20'd0, bcd}, {20'd0, exp_bcd});
    @(posedge clk); #1;
    check_eq("done_pulse", {31'd0, done}, 32'd0);
    check_eq("busy_end", {31'd0, busy}, 32'd0);
    check_eq("res_hold", {23'd0, resultado}, {23'd0, exp_res});
  endtask

  initial begin
    int dones;
    int edges;
    rst = 1'b1; start = 1'b0; Sel = 1'b0; A = 8'd0; B = 8'd0;
    start4 = 1'b0; Sel4 = 1'b0; A4 = 4'd0; B4 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_res", {23'd0, resultado}, 32'd0);
    check_eq("rst_neg", {31'd0, negative}, 32'd0);
    check_eq("rst_bcd", {20'd0, bcd}, 32'd0);
    rst = 1'b0;

    run_op(8'd1,   8'd255, 1'b0, 9'h100, 1'b0, 12'h256);
    run_op(8'd2,   8'd4,   1'b1, 9'h1FE, 1'b1, 12'h002);
    run_op(8'd0,   8'd255, 1'b1, 9'h101, 1'b1, 12'h255);
    run_op(8'd1,   8'd1,   1'b1, 9'h000, 1'b0, 12'h000);
    run_op(8'd255, 8'd255, 1'b0, 9'h1FE, 1'b0, 12'h510);

    // start during CONVERT with changed operands must be ignored
    @(negedge clk);
    A = 8'd10; B = 8'd3; Sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold_conv_res", {23'd0, resultado}, 32'h1FE);
    check_eq("hold_conv_bcd", {20'd0, bcd}, 32'h510);
    A = 8'd99; B = 8'd50; Sel = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (done) dones++;
    check_eq("busy_ign_done", dones, 1);
    check_eq("busy_ign_res", {23'd0, resultado}, 32'd13);
    check_eq("busy_ign_bcd", {20'd0, bcd}, 32'h013);
    @(posedge clk); #1;
    check_eq("busy_ign_single", {31'd0, done}, 32'd0);
    run_op(8'd20, 8'd22, 1'b0, 9'd42, 1'b0, 12'h042);

    // reset in the middle of CONVERT
    @(negedge clk);
    A = 8'd128; B = 8'd128; Sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    check_eq("mid_rst_res", {23'd0, resultado}, 32'd0);
    check_eq("mid_rst_neg", {31'd0, negative}, 32'd0);
    check_eq("mid_rst_bcd", {20'd0, bcd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_eq("no_done_after_rst", dones, 0);
    run_op(8'd7, 8'd9, 1'b1, 9'h1FE, 1'b1, 12'h002);

    // narrow variant
    @(negedge clk);
    A4 = 4'd15; B4 = 4'd15; Sel4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    edges = 1;
    while (!done4 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq("w4_latency", edges, 7);
    check_eq("w4_res", {27'd0, resultado4}, 32'd30);
    check_eq("w4_neg", {31'd0, negative4}, 32'd0);
    check_eq("w4_bcd", {24'd0, bcd4}, 32'h30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
